// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and saturation helper for the neuron MAC datapath.
package neuron_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2
    } act_mode_t;

    typedef enum logic [1:0] {IDLE, MAC, BIAS, OUTPUT} state_t;

    localparam int LEAKY_SHIFT = 3;

    // Values up to 64 bits wide; callers truncate the result to the target width.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

endpackage

// File: rtl/neuron_weight_bank.sv
// neuron_weight_bank: weight storage with one write port and one async read port per lane.
module neuron_weight_bank #(
    parameter int numWeights  = 256,
    parameter int numLanes    = 4,
    parameter int weightWidth = 16,
    parameter int beatWidth   = 6,
    parameter int addrWidth   = 8
) (
    input  logic                            clk,
    input  logic                            writeEn,
    input  logic [addrWidth-1:0]            writeAddr,
    input  logic [weightWidth-1:0]          writeData,
    input  logic [beatWidth-1:0]            beat,
    output logic [numLanes*weightWidth-1:0] rdData
);

    logic [weightWidth-1:0] mem [numWeights];

    always_ff @(posedge clk) begin
        if (writeEn) mem[writeAddr] <= writeData;
    end

    for (genvar k = 0; k < numLanes; k++) begin : g_read
        logic [addrWidth-1:0] addr;
        assign addr = addrWidth'(int'(beat) * numLanes + k);
        assign rdData[k*weightWidth +: weightWidth] = mem[addr];
    end

endmodule

// File: rtl/neuron_mac_array.sv
// neuron_mac_array: streaming dot product against stored weights, plus bias and selectable activation.
module neuron_mac_array
    import neuron_pkg::*;
#(
    parameter int layerNumber     = 0,
    parameter int neuronNumber    = 0,
    parameter int numWeights      = 256,
    parameter int numLanes        = 4,
    parameter int dataWidth       = 16,
    parameter int dataFracWidth   = 10,
    parameter int weightWidth     = 16,
    parameter int weightFracWidth = 10,
    parameter int accWidth        = dataWidth + weightWidth + $clog2(numLanes),
    localparam int addrWidth      = $clog2(numWeights)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [numLanes*dataWidth-1:0] inData,
    input  logic                          inValid,
    output logic                          inReady,
    input  logic [1:0]                    actMode,
    input  logic                          cfgWriteEn,
    input  logic                          cfgIsBias,
    input  logic [31:0]                   cfgLayer,
    input  logic [31:0]                   cfgNeuron,
    input  logic [addrWidth-1:0]          cfgAddr,
    input  logic [weightWidth-1:0]        cfgData,
    output logic                          cfgError,
    output logic [dataWidth-1:0]          outData,
    output logic                          outValid,
    input  logic                          outReady
);

    localparam int numBeats  = numWeights / numLanes;
    localparam int beatW     = (numBeats > 1) ? $clog2(numBeats) : 1;
    localparam int prodWidth = dataWidth + weightWidth;

    state_t                            state;
    logic [beatW-1:0]                  beat;
    logic signed [accWidth-1:0]        acc;
    logic                              satFlag;
    logic [1:0]                        mode;
    logic signed [weightWidth-1:0]     bias;
    logic [numLanes*weightWidth-1:0]   laneWeights;
    logic signed [prodWidth-1:0]       prod [numLanes];
    logic signed [accWidth-1:0]        laneSum;
    logic signed [accWidth-1:0]        accBase;
    logic signed [accWidth:0]          accSum;
    logic signed [accWidth-1:0]        accNext;
    logic                              ovf;
    logic signed [accWidth:0]          biasSum;
    logic signed [accWidth-1:0]        biasSat;
    logic signed [accWidth-1:0]        shifted;
    logic signed [dataWidth-1:0]       conv;
    logic signed [dataWidth-1:0]       leaky;
    logic [dataWidth-1:0]              result;
    logic                              cfgHit;
    logic                              beat0Clash;
    logic                              cfgAllowed;
    logic                              lastBeat;

    assign inReady    = (state == IDLE) || (state == MAC);
    assign lastBeat   = beat == beatW'(numBeats - 1);
    assign cfgHit     = cfgWriteEn && cfgLayer == 32'(layerNumber) && cfgNeuron == 32'(neuronNumber);
    // A beat accepted from IDLE reads lanes 0..numLanes-1, so a same-cycle write there is refused.
    assign beat0Clash = state == IDLE && inValid && !cfgIsBias && 32'(cfgAddr) < 32'(numLanes);
    assign cfgAllowed = state == IDLE && !beat0Clash;

    neuron_weight_bank #(
        .numWeights (numWeights),
        .numLanes   (numLanes),
        .weightWidth(weightWidth),
        .beatWidth  (beatW),
        .addrWidth  (addrWidth)
    ) weightBank (
        .clk      (clk),
        .writeEn  (cfgHit && cfgAllowed && !cfgIsBias),
        .writeAddr(cfgAddr),
        .writeData(cfgData),
        .beat     (beat),
        .rdData   (laneWeights)
    );

    always_ff @(posedge clk) begin
        if (cfgHit && cfgAllowed && cfgIsBias) bias <= cfgData;
    end

    for (genvar k = 0; k < numLanes; k++) begin : g_lane
        assign prod[k] = prodWidth'($signed(inData[k*dataWidth +: dataWidth]))
                       * prodWidth'($signed(laneWeights[k*weightWidth +: weightWidth]));
    end

    always_comb begin
        laneSum = '0;
        for (int k = 0; k < numLanes; k++) laneSum = laneSum + accWidth'(prod[k]);
    end

    assign accBase = (state == IDLE) ? '0 : acc;
    assign accSum  = (accWidth+1)'(accBase) + (accWidth+1)'(laneSum);
    assign ovf     = accSum[accWidth] ^ accSum[accWidth-1];
    assign accNext = accWidth'(sat_trunc(64'(accSum), accWidth));

    // Bias is aligned to the product's fractional point before the add.
    assign biasSum = (accWidth+1)'(acc) + ((accWidth+1)'(bias) <<< dataFracWidth);
    assign biasSat = accWidth'(sat_trunc(64'(biasSum), accWidth));
    assign shifted = biasSat >>> weightFracWidth;
    assign conv    = dataWidth'(sat_trunc(64'(shifted), dataWidth));
    assign leaky   = conv >>> LEAKY_SHIFT;
    assign result  = (conv[dataWidth-1] && mode == ACT_RELU)  ? '0 :
                     (conv[dataWidth-1] && mode == ACT_LEAKY) ? leaky : conv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat     <= '0;
            acc      <= '0;
            satFlag  <= 1'b0;
            mode     <= ACT_LINEAR;
            outData  <= '0;
            outValid <= 1'b0;
            cfgError <= 1'b0;
        end else begin
            cfgError <= cfgHit && !cfgAllowed;
            case (state)
                IDLE: if (inValid) begin
                    acc     <= accNext;
                    satFlag <= ovf;
                    mode    <= actMode;
                    beat    <= (numBeats == 1) ? '0 : beatW'(1);
                    state   <= (numBeats == 1) ? BIAS : MAC;
                end
                MAC: if (inValid) begin
                    if (!satFlag) acc <= accNext;
                    satFlag <= satFlag | ovf;
                    beat    <= lastBeat ? '0 : beat + 1'b1;
                    if (lastBeat) state <= BIAS;
                end
                BIAS: begin
                    outData  <= result;
                    outValid <= 1'b1;
                    state    <= OUTPUT;
                end
                OUTPUT: if (outReady) begin
                    outValid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_array.sv
// tb_neuron_mac_array: directed vectors with a scoreboard queue checked by an output monitor.
module tb_neuron_mac_array;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] inData = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [1:0]  actMode = 2'd0;
    logic        cfgWriteEn = 1'b0;
    logic        cfgIsBias = 1'b0;
    logic [31:0] cfgLayer = '0;
    logic [31:0] cfgNeuron = '0;
    logic [2:0]  cfgAddr = '0;
    logic [15:0] cfgData = '0;
    logic        cfgError;
    logic [15:0] outData;
    logic        outValid;
    logic        outReady = 1'b1;

    int          nCompared = 0;
    int          nMismatch = 0;
    logic [15:0] expQ [$];
    logic [15:0] expVal;
    logic        err;

    localparam logic [63:0] ONES  = {4{16'h0400}};
    localparam logic [63:0] TWOS  = {4{16'h0800}};
    localparam logic [63:0] NEGS  = {4{16'hFC00}};
    localparam logic [63:0] MAXES = {4{16'h7FFF}};

    always #5 clk = ~clk;

    neuron_mac_array #(
        .numWeights(8),
        .numLanes  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inData    (inData),
        .inValid   (inValid),
        .inReady   (inReady),
        .actMode   (actMode),
        .cfgWriteEn(cfgWriteEn),
        .cfgIsBias (cfgIsBias),
        .cfgLayer  (cfgLayer),
        .cfgNeuron (cfgNeuron),
        .cfgAddr   (cfgAddr),
        .cfgData   (cfgData),
        .cfgError  (cfgError),
        .outData   (outData),
        .outValid  (outValid),
        .outReady  (outReady)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && outValid && outReady) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL unexpected output: got %h, expected none", outData);
            end else begin
                expVal = expQ.pop_front();
                check("outData", {16'h0, outData}, {16'h0, expVal});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic isBias, input logic [31:0] neuron, input logic [2:0] addr,
                            input logic [15:0] data, output logic e);
        cfgWriteEn = 1'b1;
        cfgIsBias  = isBias;
        cfgLayer   = 32'd0;
        cfgNeuron  = neuron;
        cfgAddr    = addr;
        cfgData    = data;
        step();
        e = cfgError;
        cfgWriteEn = 1'b0;
    endtask

    task automatic loadAll(input logic [15:0] w, input logic [15:0] b);
        logic e;
        for (int i = 0; i < 8; i++) cfgWrite(1'b0, 32'd0, 3'(i), w, e);
        cfgWrite(1'b1, 32'd0, 3'd0, b, e);
        check("load cfgError", {31'h0, e}, 32'h0);
    endtask

    task automatic sendBeat(input logic [63:0] d);
        int guard = 0;
        inData  = d;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!inReady) begin
            nCompared++;
            nMismatch++;
            $display("FAIL accept timeout: got inReady=0, expected 1");
        end
        step();
        inValid = 1'b0;
    endtask

    task automatic sendVec(input logic [63:0] b0, input logic [63:0] b1, input logic [1:0] m,
                           input logic [15:0] exp);
        expQ.push_back(exp);
        actMode = m;
        sendBeat(b0);
        sendBeat(b1);
    endtask

    task automatic waitIdle();
        repeat (3) step();
    endtask

    initial begin
        int guard;
        repeat (3) step();
        check("reset outValid", {31'h0, outValid}, 32'h0);
        check("reset outData", {16'h0, outData}, 32'h0);
        check("reset cfgError", {31'h0, cfgError}, 32'h0);
        check("reset inReady", {31'h0, inReady}, 32'h1);
        reset = 1'b1;
        step();

        // ones . ones + 0.5 = 8.5, valid one cycle after the last beat
        loadAll(16'h0400, 16'h0200);
        sendVec(ONES, ONES, 2'd1, 16'h2200);
        check("latency outValid at N", {31'h0, outValid}, 32'h0);
        step();
        check("latency outValid at N+1", {31'h0, outValid}, 32'h1);
        check("latency outData at N+1", {16'h0, outData}, 32'h2200);
        waitIdle();

        // matching write while busy is dropped and flagged
        expQ.push_back(16'h2200);
        actMode = 2'd1;
        sendBeat(ONES);
        cfgWrite(1'b0, 32'd0, 3'd5, 16'h0000, err);
        check("busy write cfgError", {31'h0, err}, 32'h1);
        step();
        check("cfgError one cycle", {31'h0, cfgError}, 32'h0);
        sendBeat(ONES);
        waitIdle();
        cfgWrite(1'b0, 32'd1, 3'd0, 16'h0000, err);
        check("nonmatching cfgError", {31'h0, err}, 32'h0);

        // write to a beat-0 weight on the accepting cycle is refused
        expQ.push_back(16'h2200);
        inData = ONES; inValid = 1'b1;
        cfgWriteEn = 1'b1; cfgIsBias = 1'b0; cfgNeuron = 32'd0; cfgAddr = 3'd1; cfgData = 16'h0000;
        step();
        check("clash cfgError", {31'h0, cfgError}, 32'h1);
        inValid = 1'b0; cfgWriteEn = 1'b0;
        sendBeat(ONES);
        waitIdle();

        // reset mid-vector
        actMode = 2'd1;
        sendBeat(ONES);
        reset = 1'b0;
        #1;
        check("midreset outValid", {31'h0, outValid}, 32'h0);
        check("midreset outData", {16'h0, outData}, 32'h0);
        check("midreset inReady", {31'h0, inReady}, 32'h1);
        step();
        reset = 1'b1;
        step();
        sendVec(ONES, ONES, 2'd1, 16'h2200);
        waitIdle();

        // output backpressure stalls the next vector
        outReady = 1'b0;
        sendVec(ONES, ONES, 2'd1, 16'h2200);
        step();
        inData = TWOS; inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall outValid", {31'h0, outValid}, 32'h1);
            check("stall outData", {16'h0, outData}, 32'h2200);
            check("stall inReady", {31'h0, inReady}, 32'h0);
            step();
        end
        outReady = 1'b1;
        sendVec(TWOS, TWOS, 2'd0, 16'h4200);
        waitIdle();

        // negative sum through each activation
        cfgWrite(1'b1, 32'd0, 3'd0, 16'h0000, err);
        sendVec(NEGS, NEGS, 2'd0, 16'hE000);
        waitIdle();
        sendVec(NEGS, NEGS, 2'd1, 16'h0000);
        waitIdle();
        sendVec(NEGS, NEGS, 2'd2, 16'hFC00);
        waitIdle();
        sendVec(NEGS, NEGS, 2'd3, 16'hE000);
        waitIdle();

        // saturation at both extremes
        loadAll(16'h7FFF, 16'h7FFF);
        sendVec(MAXES, MAXES, 2'd0, 16'h7FFF);
        waitIdle();
        loadAll(16'h8000, 16'h8000);
        sendVec(MAXES, MAXES, 2'd0, 16'h8000);
        waitIdle();

        guard = 0;
        while (expQ.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        check("scoreboard drained", expQ.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/neuron_mac_array.md
Name: neuron_mac_array

Overview:
- Next-generation layer neuron: dot product of a `numWeights`-element input vector against stored weights, plus bias, then a run-time selectable activation.
- Consumes `numLanes` inputs per beat over a valid/ready stream.
- Presents the result on a valid/ready output, then returns to IDLE so it can process back-to-back vectors.
- Sits inside a layer module; one instance per neuron, with weights and bias loaded at run time through the config write port.

Parameters:
- layerNumber, 0, layer index; compared against cfgLayer for writes.
- neuronNumber, 0, neuron index; compared against cfgNeuron for writes.
- numWeights, 256, vector length; must be a multiple of numLanes.
- numLanes, 4, parallel inputs/multipliers per beat (1..16).
- dataWidth, 16, signed activation width.
- dataFracWidth, 10, activation fractional bits.
- weightWidth, 16, signed weight/bias width.
- weightFracWidth, 10, weight/bias fractional bits.
- accWidth, dataWidth+weightWidth+$clog2(numLanes), signed accumulator width.
- Derived: numBeats = numWeights/numLanes; beatWidth = $clog2(numBeats); addrWidth = $clog2(numWeights).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- inData  in  numLanes*dataWidth  lane k occupies bits [k*dataWidth +: dataWidth]; lane k = element beat*numLanes+k.
- inValid  in  1  input beat valid.
- inReady  out  1  block can accept a beat.
- actMode  in  2  0 linear, 1 ReLU, 2 leaky ReLU (x>>>3 for negatives), 3 reserved (treated as linear); sampled on first beat.
- cfgWriteEn  in  1  config write strobe.
- cfgIsBias  in  1  1 = bias write, 0 = weight write.
- cfgLayer  in  32  target layer.
- cfgNeuron  in  32  target neuron.
- cfgAddr  in  addrWidth  weight index.
- cfgData  in  weightWidth  write data.
- cfgError  out  1  one-cycle pulse when a matching write is dropped because the block is busy.
- outData  out  dataWidth  activated result.
- outValid  out  1  result valid.
- outReady  in  1  downstream accepts result.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; beat counter, accumulator and outData = 0.
  - outValid = 0, cfgError = 0.
  - Weight and bias storage is not reset.
  - Reset mid-vector aborts the vector; partial sums are discarded.
- States:
  - IDLE: inReady=1. On inValid, accumulate beat 0, latch actMode, go to MAC. If numBeats==1, go to BIAS instead.
  - MAC: inReady=1. Accumulate on each inValid&&inReady. Gaps with inValid=0 hold all state. When beat numBeats-1 is accepted, go to BIAS.
  - BIAS: inReady=0. Add bias, activate, register the result into outData, set outValid=1. Go to OUTPUT.
  - OUTPUT: inReady=0. outValid and outData hold until outReady=1, then outValid=0 and go to IDLE.
- Latency:
  - Last beat accepted at edge N gives outValid=1 after edge N+1.
  - Minimum vector period is numBeats+2 cycles with outReady tied high.
- Arithmetic:
  - Each lane product is signed dataWidth x weightWidth with dataFracWidth+weightFracWidth fractional bits.
  - Lane products are summed in a combinational adder tree, sign-extended to accWidth, then added to the accumulator.
  - Accumulator saturates to the accWidth max/min on signed overflow; saturation is sticky within a vector.
  - Bias is sign-extended and shifted left by dataFracWidth before the add; the add saturates.
  - Output conversion: arithmetic shift right by weightFracWidth (truncate toward -inf), then saturate to the dataWidth signed range.
  - Activation is applied after conversion. ReLU maps negatives to 0. Leaky ReLU maps negatives to x>>>3.
- Config writes:
  - A write is honoured only when cfgLayer==layerNumber and cfgNeuron==neuronNumber.
  - A matching write takes effect only in IDLE. In any other state it is dropped and cfgError pulses for one cycle.
  - A write to the same weight in the same cycle that a beat is accepted from IDLE is also dropped and flagged; the beat uses the old weight.
  - Non-matching writes are silently ignored.
- Weight storage is asynchronous-read, one read port per lane, indexed {beat, lane}.

Decomposition:
- Package neuron_pkg contains:
  - act_mode_t enum (ACT_LINEAR, ACT_RELU, ACT_LEAKY).
  - state_t enum (IDLE, MAC, BIAS, OUTPUT).
  - function sat_trunc (signed saturate to a given width).
  - Leaky shift constant LEAKY_SHIFT=3.
- One sub-module, neuron_weight_bank:
  - numWeights x weightWidth storage with one write port and numLanes async read ports.

Test Plan:
1. numLanes=4, numWeights=8. All weights 1.0 (0x0400), bias 0.5 (0x0200), inputs 1.0 over 2 beats, ReLU -> outData=0x2200 (8.5), outValid one cycle after last beat.
2. Same weights, inputs all -1.0, bias 0. Linear -> 0xE000 (-8.0); ReLU -> 0x0000; leaky -> 0xFC00 (-1.0).
3. Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF, linear -> outData saturates to 0x7FFF; all negative extremes -> 0x8000.
4. Hold outReady=0 for 5 cycles -> outValid and outData stable, inReady=0, a second vector is stalled. Release -> result consumed, IDLE reached, next vector completes correctly.
5. Matching weight write during MAC -> cfgError pulse, weight unchanged. Non-matching cfgNeuron during IDLE -> no write, no error.
6. Assert reset=0 after beat 1 of 2 -> outValid=0, state IDLE immediately. After release, a fresh vector gives the scenario-1 result.
